// File: rtl/digit_counter.sv
// digit_counter: single-digit modulo counter stage for the stopwatch datapath.
// The current digit comes in on numberIn (normally numberOut fed back) and the
// registered successor, wrapping MAX_VALUE -> 0, appears on numberOut.
module digit_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] numberIn,
    output logic [WIDTH-1:0] numberOut
);

    // Limit and increment carried at WIDTH+1 bits so an all-ones input cannot
    // silently wrap back into the legal range.
    localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(MAX_VALUE);

    logic [WIDTH:0]   succ;
    logic [WIDTH-1:0] next;

    // Successor of the incoming digit; anything past MAX_VALUE (normal wrap or
    // an illegal input digit) collapses to zero, so the stage self-corrects.
    always_comb begin
        succ = {1'b0, numberIn} + (WIDTH + 1)'(1);
        next = '0;
        if (succ <= MAXV)
            next = succ[WIDTH-1:0];
    end

    // Digit register: reset wins over enable; with enable low the digit holds.
    always_ff @(posedge clk) begin
        if (rst)
            numberOut <= '0;
        else if (enable)
            numberOut <= next;
    end

endmodule

// File: tb/tb_digit_counter.sv
// tb_digit_counter: table-driven check of digit_counter (BCD default) plus a
// hand-written sequence for a MAX_VALUE=5 instance. Expected values are pushed
// to a scoreboard queue when stimulus is driven and popped after the edge.
module tb_digit_counter;

    logic       clk = 1'b0;
    logic       rst_a, en_a, rst_b, en_b;
    logic [3:0] in_a, in_b, out_a, out_b;

    always #5 clk = ~clk;

    digit_counter #(.WIDTH(4), .MAX_VALUE(9)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .numberIn(in_a), .numberOut(out_a)
    );

    digit_counter #(.WIDTH(4), .MAX_VALUE(5)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .numberIn(in_b), .numberOut(out_b)
    );

    // fb=1: numberIn is driven with the bench's own current digit (feedback use)
    typedef struct {
        bit         rst;
        bit         en;
        bit         fb;
        logic [3:0] in;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        int         sel;
        int         idx;
        logic [3:0] exp;
    } sb_t;

    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] cur_a, cur_b;   // bench-side copy of each digit

    // Drive one edge on the selected DUT, score it one step after the edge.
    task automatic step(input int sel, input int idx, input bit r, input bit e,
                        input logic [3:0] din, input logic [3:0] exp);
        sb_t        ent;
        logic [3:0] got;
        @(negedge clk);
        if (sel == 0) begin rst_a = r; en_a = e; in_a = din; end
        else          begin rst_b = r; en_b = e; in_b = din; end
        sb.push_back('{sel: sel, idx: idx, exp: exp});
        @(posedge clk);
        #1;
        ent = sb.pop_front();
        got = (ent.sel == 0) ? out_a : out_b;
        checks++;
        if (got !== ent.exp) begin
            failures++;
            $display("FAIL dut%0s step%0d: numberOut=%0d expected=%0d",
                     (ent.sel == 0) ? "A" : "B", ent.idx, got, ent.exp);
        end
        if (sel == 0) begin cur_a = exp; en_a = 1'b0; rst_a = 1'b0; end
        else          begin cur_b = exp; en_b = 1'b0; rst_b = 1'b0; end
    endtask

    vec_t tab[$];
    vec_t tb5[$];

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b0; in_a = '0; cur_a = '0;
        rst_b = 1'b1; en_b = 1'b0; in_b = '0; cur_b = '0;

        // BCD instance: reset, feedback count, wrap/illegal, hold, reset priority
        tab = '{
            '{1, 1, 0, 4'd5,  4'd0},   // reset with enable/numberIn active
            '{1, 1, 0, 4'd5,  4'd0},   // still reset
            '{0, 1, 1, 4'd0,  4'd1},   // feedback count 1..9,0,1
            '{0, 1, 1, 4'd0,  4'd2},
            '{0, 1, 1, 4'd0,  4'd3},
            '{0, 1, 1, 4'd0,  4'd4},
            '{0, 1, 1, 4'd0,  4'd5},
            '{0, 1, 1, 4'd0,  4'd6},
            '{0, 1, 1, 4'd0,  4'd7},
            '{0, 1, 1, 4'd0,  4'd8},
            '{0, 1, 1, 4'd0,  4'd9},
            '{0, 1, 1, 4'd0,  4'd0},   // wrap
            '{0, 1, 1, 4'd0,  4'd1},
            '{0, 1, 0, 4'd9,  4'd0},   // explicit wrap
            '{0, 1, 0, 4'd12, 4'd0},   // illegal digit self-corrects
            '{0, 1, 0, 4'd15, 4'd0},   // all-ones, no overflow into legal range
            '{0, 1, 0, 4'd10, 4'd0},
            '{0, 1, 0, 4'd8,  4'd9},   // last legal increment
            '{0, 1, 0, 4'd3,  4'd4},
            '{0, 0, 0, 4'd0,  4'd4},   // hold, numberIn ignored
            '{0, 0, 0, 4'd7,  4'd4},
            '{0, 0, 0, 4'd9,  4'd4},
            '{0, 0, 0, 4'd15, 4'd4},
            '{0, 1, 0, 4'd4,  4'd5},   // resume
            '{0, 1, 0, 4'd6,  4'd7},
            '{1, 1, 0, 4'd7,  4'd0},   // reset beats enable (not 8)
            '{0, 1, 1, 4'd0,  4'd1},
            '{0, 1, 1, 4'd0,  4'd2},
            '{1, 0, 0, 4'd3,  4'd0},   // reset with enable low
            '{0, 0, 0, 4'd5,  4'd0}    // hold at zero after reset
        };

        foreach (tab[i])
            step(0, i, tab[i].rst, tab[i].en,
                 tab[i].fb ? cur_a : tab[i].in, tab[i].exp);

        // MAX_VALUE=5 instance: seconds-tens style digit
        tb5 = '{
            '{1, 0, 0, 4'd0,  4'd0},
            '{0, 1, 1, 4'd0,  4'd1},
            '{0, 1, 1, 4'd0,  4'd2},
            '{0, 1, 1, 4'd0,  4'd3},
            '{0, 1, 1, 4'd0,  4'd4},
            '{0, 1, 1, 4'd0,  4'd5},
            '{0, 1, 1, 4'd0,  4'd0},   // wrap at 5
            '{0, 1, 0, 4'd6,  4'd0},   // illegal for this modulus
            '{0, 1, 0, 4'd4,  4'd5},
            '{0, 1, 0, 4'd9,  4'd0},
            '{0, 1, 0, 4'd15, 4'd0}
        };

        foreach (tb5[i])
            step(1, i, tb5[i].rst, tb5[i].en,
                 tb5[i].fb ? cur_b : tb5[i].in, tb5[i].exp);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: entries=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
